rtc_calendar: RTL and testbench

Single-clock real-time calendar: a prescaler turns `clk` into a one-second tick, and the tick advances a synchronous sec/min/hour/day/month/year chain. Months have their true lengths and leap years follow the full Gregorian rule. The block replaces ripple-clocked counter chains, so every field updates on the same `clk` edge. It also provides a validated time-set handshake, per-field carry strobes and a daily hh:mm:ss alarm.

---
 rtl/rtc_pkg.sv | 30 +++
 rtl/mod_counter.sv | 33 +++
 rtl/rtc_calendar.sv | 152 +++++++++++++++
 tb/tb_rtc_calendar.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared field widths, field limits and calendar helpers for the real-time calendar.
package rtc_pkg;

  localparam int unsigned MONTH_W = 4;
  localparam int unsigned DAY_W   = 5;
  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;

  localparam int unsigned SEC_LIM   = 60;
  localparam int unsigned MIN_LIM   = 60;
  localparam int unsigned HOUR_LIM  = 24;
  localparam int unsigned MONTH_LIM = 12;

  function automatic logic is_leap(input logic [31:0] year);
    return (((year % 4) == 0) && ((year % 100) != 0)) || ((year % 400) == 0);
  endfunction

  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic [31:0]        year);
    logic [DAY_W-1:0] dim;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = is_leap(year) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Loadable modulo counter running MIN..max, where max is an input so limits may vary.
module mod_counter #(
  parameter int unsigned W       = 6,
  parameter int unsigned MIN     = 0,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] MIN_V = W'(MIN);
  localparam logic [W-1:0] RST_V = W'(RST_VAL);

  // >= keeps the counter recoverable if max shrinks below the current count
  assign wrap = en && (cnt >= max);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= RST_V;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= wrap ? MIN_V : cnt + W'(1);
    end
  end

endmodule

// File: rtl/rtc_calendar.sv
// Single-clock calendar: prescaler tick drives a synchronous sec..year carry chain,
// with a validated time-set port, per-field carry strobes and a daily alarm.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned YEAR_W        = 12,
  parameter int unsigned RST_YEAR      = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               set_valid,
  output logic               set_ready,
  input  logic [YEAR_W-1:0]  set_year,
  input  logic [MONTH_W-1:0] set_month,
  input  logic [DAY_W-1:0]   set_day,
  input  logic [HOUR_W-1:0]  set_hour,
  input  logic [MIN_W-1:0]   set_min,
  input  logic [SEC_W-1:0]   set_sec,
  output logic               set_err,
  output logic [YEAR_W-1:0]  year,
  output logic [MONTH_W-1:0] month,
  output logic [DAY_W-1:0]   day,
  output logic [HOUR_W-1:0]  hour,
  output logic [MIN_W-1:0]   min,
  output logic [SEC_W-1:0]   sec,
  output logic               sec_stb,
  output logic               min_stb,
  output logic               hour_stb,
  output logic               day_stb,
  output logic               month_stb,
  output logic               year_stb,
  input  logic               alm_wr,
  input  logic               alm_en,
  input  logic [HOUR_W-1:0]  alm_hour,
  input  logic [MIN_W-1:0]   alm_min,
  input  logic [SEC_W-1:0]   alm_sec,
  output logic               alm_hit
);

  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]   SEC_MAX   = SEC_W'(SEC_LIM - 1);
  localparam logic [MIN_W-1:0]   MIN_MAX   = MIN_W'(MIN_LIM - 1);
  localparam logic [HOUR_W-1:0]  HOUR_MAX  = HOUR_W'(HOUR_LIM - 1);
  localparam logic [MONTH_W-1:0] MONTH_MAX = MONTH_W'(MONTH_LIM);
  localparam logic [YEAR_W-1:0]  YEAR_MAX  = '1;

  logic [PRE_W-1:0]  pre_q;
  logic              set_ready_q, set_err_q, alm_hit_q;
  logic              sec_stb_q, min_stb_q, hour_stb_q, day_stb_q, month_stb_q, year_stb_q;
  logic [HOUR_W-1:0] alm_hour_q;
  logic [MIN_W-1:0]  alm_min_q;
  logic [SEC_W-1:0]  alm_sec_q;
  logic              tick, set_xfer, set_ok, load, step;
  logic              sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap, year_wrap;
  logic [DAY_W-1:0]  day_max;

  // set_ready also gates the prescaler, so the first edge after reset release does not count
  assign tick     = run && set_ready_q && (pre_q == PRE_MAX);
  assign set_xfer = set_valid && set_ready_q;
  assign set_ok   = (set_month != '0) && (set_month <= MONTH_MAX) &&
                    (set_day != '0) && (set_day <= days_in_month(set_month, 32'(set_year))) &&
                    (set_hour <= HOUR_MAX) && (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);
  assign load     = set_xfer && set_ok;
  assign step     = tick && !load;
  assign day_max  = days_in_month(month, 32'(year));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else if (load || tick) begin
      pre_q <= '0;
    end else if (run && set_ready_q) begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  mod_counter #(.W(SEC_W), .MIN(0), .RST_VAL(0)) u_sec (
    .clk(clk), .rst(rst), .en(step), .load(load), .load_val(set_sec), .max(SEC_MAX),
    .cnt(sec), .wrap(sec_wrap)
  );
  mod_counter #(.W(MIN_W), .MIN(0), .RST_VAL(0)) u_min (
    .clk(clk), .rst(rst), .en(sec_wrap), .load(load), .load_val(set_min), .max(MIN_MAX),
    .cnt(min), .wrap(min_wrap)
  );
  mod_counter #(.W(HOUR_W), .MIN(0), .RST_VAL(0)) u_hour (
    .clk(clk), .rst(rst), .en(min_wrap), .load(load), .load_val(set_hour), .max(HOUR_MAX),
    .cnt(hour), .wrap(hour_wrap)
  );
  mod_counter #(.W(DAY_W), .MIN(1), .RST_VAL(1)) u_day (
    .clk(clk), .rst(rst), .en(hour_wrap), .load(load), .load_val(set_day), .max(day_max),
    .cnt(day), .wrap(day_wrap)
  );
  mod_counter #(.W(MONTH_W), .MIN(1), .RST_VAL(1)) u_month (
    .clk(clk), .rst(rst), .en(day_wrap), .load(load), .load_val(set_month), .max(MONTH_MAX),
    .cnt(month), .wrap(month_wrap)
  );
  mod_counter #(.W(YEAR_W), .MIN(0), .RST_VAL(RST_YEAR)) u_year (
    .clk(clk), .rst(rst), .en(month_wrap), .load(load), .load_val(set_year), .max(YEAR_MAX),
    .cnt(year), .wrap(year_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_ready_q <= 1'b0;
      set_err_q   <= 1'b0;
      sec_stb_q   <= 1'b0;
      min_stb_q   <= 1'b0;
      hour_stb_q  <= 1'b0;
      day_stb_q   <= 1'b0;
      month_stb_q <= 1'b0;
      year_stb_q  <= 1'b0;
      alm_hour_q  <= '0;
      alm_min_q   <= '0;
      alm_sec_q   <= '0;
      alm_hit_q   <= 1'b0;
    end else begin
      set_ready_q <= 1'b1;
      set_err_q   <= set_xfer && !set_ok;
      sec_stb_q   <= step;
      min_stb_q   <= sec_wrap;
      hour_stb_q  <= min_wrap;
      day_stb_q   <= hour_wrap;
      month_stb_q <= day_wrap;
      year_stb_q  <= month_wrap;
      if (alm_wr) begin
        alm_hour_q <= alm_hour;
        alm_min_q  <= alm_min;
        alm_sec_q  <= alm_sec;
      end
      // Only a tick-driven second can match, so a set landing on the alarm time stays silent
      alm_hit_q <= alm_en && sec_stb_q && (hour == alm_hour_q) && (min == alm_min_q) &&
                   (sec == alm_sec_q);
    end
  end

  assign set_ready = set_ready_q;
  assign set_err   = set_err_q;
  assign sec_stb   = sec_stb_q;
  assign min_stb   = min_stb_q;
  assign hour_stb  = hour_stb_q;
  assign day_stb   = day_stb_q;
  assign month_stb = month_stb_q;
  assign year_stb  = year_stb_q;
  assign alm_hit   = alm_hit_q;

  logic unused_year_wrap;
  assign unused_year_wrap = year_wrap;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed plus randomized bench for rtc_calendar against a calendar-arithmetic reference model.
module tb_rtc_calendar;

  localparam int T  = 4;
  localparam int YW = 12;

  logic          clk, rst, run, set_valid, set_ready, set_err;
  logic [YW-1:0] set_year, year;
  logic [3:0]    set_month, month;
  logic [4:0]    set_day, day, set_hour, hour, alm_hour;
  logic [5:0]    set_min, min, set_sec, sec, alm_min, alm_sec;
  logic          sec_stb, min_stb, hour_stb, day_stb, month_stb, year_stb;
  logic          alm_wr, alm_en, alm_hit;

  rtc_calendar #(.TICKS_PER_SEC(T), .YEAR_W(YW), .RST_YEAR(2000)) dut (
    .clk(clk), .rst(rst), .run(run), .set_valid(set_valid), .set_ready(set_ready),
    .set_year(set_year), .set_month(set_month), .set_day(set_day), .set_hour(set_hour),
    .set_min(set_min), .set_sec(set_sec), .set_err(set_err),
    .year(year), .month(month), .day(day), .hour(hour), .min(min), .sec(sec),
    .sec_stb(sec_stb), .min_stb(min_stb), .hour_stb(hour_stb), .day_stb(day_stb),
    .month_stb(month_stb), .year_stb(year_stb),
    .alm_wr(alm_wr), .alm_en(alm_en), .alm_hour(alm_hour), .alm_min(alm_min),
    .alm_sec(alm_sec), .alm_hit(alm_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: calendar fields, seconds-phase counter, alarm and expected pulses
  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_cnt, a_h, a_m, a_s;
  bit m_ready, e_sec, e_min, e_hour, e_day, e_month, e_year, e_err, e_hit;

  function automatic int dim(input int mo, input int y);
    bit leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo == 2) return leap ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    m_y = 2000; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0; m_cnt = 0;
    a_h = 0; a_m = 0; a_s = 0; m_ready = 0;
    {e_sec, e_min, e_hour, e_day, e_month, e_year, e_err, e_hit} = '0;
  endtask

  task automatic advance_second();
    e_sec = 1; m_s++;
    if (m_s == 60) begin
      m_s = 0; e_min = 1; m_mi++;
      if (m_mi == 60) begin
        m_mi = 0; e_hour = 1; m_h++;
        if (m_h == 24) begin
          m_h = 0; e_day = 1; m_d++;
          if (m_d > dim(m_mo, m_y)) begin
            m_d = 1; e_month = 1; m_mo++;
            if (m_mo > 12) begin
              m_mo = 1; e_year = 1; m_y = (m_y + 1) % (1 << YW);
            end
          end
        end
      end
    end
  endtask

  task automatic model_edge();
    bit nhit, xfer, ok, tick;
    int sy = int'(set_year), smo = int'(set_month), sd = int'(set_day);
    nhit = alm_en && e_sec && (m_h == a_h) && (m_mi == a_m) && (m_s == a_s);
    {e_sec, e_min, e_hour, e_day, e_month, e_year, e_err} = '0;
    xfer = set_valid && m_ready;
    ok   = (smo >= 1) && (smo <= 12) && (sd >= 1) && (sd <= dim(smo, sy)) &&
           (int'(set_hour) < 24) && (int'(set_min) < 60) && (int'(set_sec) < 60);
    tick = run && m_ready && (m_cnt == T - 1);
    if (xfer && ok) begin
      m_y = sy; m_mo = smo; m_d = sd;
      m_h = int'(set_hour); m_mi = int'(set_min); m_s = int'(set_sec); m_cnt = 0;
    end else begin
      if (xfer) e_err = 1;
      if (tick) begin
        advance_second();
        m_cnt = 0;
      end else if (run && m_ready) begin
        m_cnt++;
      end
    end
    if (alm_wr) begin
      a_h = int'(alm_hour); a_m = int'(alm_min); a_s = int'(alm_sec);
    end
    e_hit   = nhit;
    m_ready = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("year", 32'(year), m_y);       chk("month", 32'(month), m_mo);
    chk("day", 32'(day), m_d);         chk("hour", 32'(hour), m_h);
    chk("min", 32'(min), m_mi);        chk("sec", 32'(sec), m_s);
    chk("sec_stb", 32'(sec_stb), 32'(e_sec));       chk("min_stb", 32'(min_stb), 32'(e_min));
    chk("hour_stb", 32'(hour_stb), 32'(e_hour));    chk("day_stb", 32'(day_stb), 32'(e_day));
    chk("month_stb", 32'(month_stb), 32'(e_month)); chk("year_stb", 32'(year_stb), 32'(e_year));
    chk("set_err", 32'(set_err), 32'(e_err));       chk("set_ready", 32'(set_ready), 32'(m_ready));
    chk("alm_hit", 32'(alm_hit), 32'(e_hit));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_set(input int y, input int mo, input int d, input int h, input int mi,
                        input int s);
    set_year = YW'(y); set_month = 4'(mo); set_day = 5'(d);
    set_hour = 5'(h);  set_min = 6'(mi);   set_sec = 6'(s);
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  task automatic chk_date(input string tag, input int y, input int mo, input int d, input int h,
                          input int mi, input int s);
    chk({tag, ".year"}, 32'(year), y);   chk({tag, ".month"}, 32'(month), mo);
    chk({tag, ".day"}, 32'(day), d);     chk({tag, ".hour"}, 32'(hour), h);
    chk({tag, ".min"}, 32'(min), mi);    chk({tag, ".sec"}, 32'(sec), s);
  endtask

  initial begin
    rst = 1'b0; run = 1'b1; set_valid = 1'b0; alm_wr = 1'b0; alm_en = 1'b0;
    set_year = '0; set_month = '0; set_day = '0; set_hour = '0; set_min = '0; set_sec = '0;
    alm_hour = '0; alm_min = '0; alm_sec = '0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    chk_date("reset", 2000, 1, 1, 0, 0, 0);
    rst = 1'b1;

    // First tick is in the fourth cycle after release; sec shows 1 on the fifth edge
    steps(4);
    chk("pre_first_tick.sec", 32'(sec), 0);
    step();
    chk("first_tick.sec", 32'(sec), 1);
    steps(4);
    chk("second_tick.sec", 32'(sec), 2);

    do_set(2023, 12, 31, 23, 59, 59);
    chk_date("set_load", 2023, 12, 31, 23, 59, 59);
    chk("set_load.sec_stb", 32'(sec_stb), 0);
    steps(T);
    chk_date("new_year", 2024, 1, 1, 0, 0, 0);
    chk("new_year.strobes",
        32'({sec_stb, min_stb, hour_stb, day_stb, month_stb, year_stb}), 32'h3f);

    do_set(2024, 2, 28, 23, 59, 59); steps(T);
    chk_date("leap2024", 2024, 2, 29, 0, 0, 0);
    do_set(2100, 2, 28, 23, 59, 59); steps(T);
    chk_date("noleap2100", 2100, 3, 1, 0, 0, 0);
    do_set(2000, 2, 28, 23, 59, 59); steps(T);
    chk_date("leap2000", 2000, 2, 29, 0, 0, 0);

    do_set(2023, 2, 29, 12, 0, 0);
    chk("bad_set.set_err", 32'(set_err), 1);
    chk_date("bad_set.unchanged", 2000, 2, 29, 0, 0, 0);
    step();
    chk("bad_set.err_once", 32'(set_err), 0);
    do_set(2024, 2, 29, 12, 0, 0);
    chk_date("good_set", 2024, 2, 29, 12, 0, 0);

    alm_hour = 5'd6; alm_min = 6'd30; alm_sec = 6'd0; alm_wr = 1'b1; alm_en = 1'b1;
    step();
    alm_wr = 1'b0;
    do_set(2024, 5, 5, 6, 29, 59);
    steps(T);
    chk("alarm.sec_stb", 32'(sec_stb), 1);
    chk("alarm.not_yet", 32'(alm_hit), 0);
    step();
    chk("alarm.hit", 32'(alm_hit), 1);
    step();
    chk("alarm.one_cycle", 32'(alm_hit), 0);
    do_set(2024, 5, 5, 6, 30, 0);
    steps(2);
    chk("alarm.set_no_fire", 32'(alm_hit), 0);
    alm_en = 1'b0;
    do_set(2024, 5, 5, 6, 29, 59);
    steps(T + 1);
    chk("alarm.disabled", 32'(alm_hit), 0);

    // Set lands exactly on the tick cycle
    do_set(2030, 7, 15, 10, 20, 30);
    steps(T - 1);
    do_set(2031, 8, 16, 11, 21, 31);
    chk_date("set_vs_tick", 2031, 8, 16, 11, 21, 31);
    chk("set_vs_tick.sec_stb", 32'(sec_stb), 0);
    steps(T);
    chk("set_vs_tick.resync", 32'(sec), 32);

    steps(2);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk_date("async_reset", 2000, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      run    = ($urandom_range(9) != 0);
      alm_en = ($urandom_range(3) != 0);
      alm_wr = 1'b0;
      if ($urandom_range(19) == 0) begin
        alm_wr   = 1'b1;
        alm_hour = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'(m_h);
        alm_min  = 6'(m_mi);
        alm_sec  = 6'((m_s + $urandom_range(3)) % 60);
      end
      set_valid = ($urandom_range(24) == 0);
      if (set_valid) begin
        set_year  = YW'($urandom);
        set_month = 4'($urandom_range(15));
        set_day   = ($urandom_range(1) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(31, 28));
        set_hour  = ($urandom_range(1) == 0) ? 5'($urandom_range(31)) : 5'd23;
        set_min   = ($urandom_range(1) == 0) ? 6'($urandom_range(63)) : 6'd59;
        set_sec   = 6'($urandom_range(63, 55));
      end
      step();
    end
    set_valid = 1'b0;
    alm_wr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
